wshb_arbiter: RTL and testbench



---
 rtl/wshb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_wshb_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wshb_arbiter
//  Description : Two-master, one-slave Wishbone arbiter for the shared SDRAM
//                port. Round-robin grant with a per-grant ack quota so a
//                master that holds cyc forever cannot starve the other one.
//  Revision    : 1.0 - initial release
// ============================================================================
module wshb_arbiter #(
  parameter int QUOTA = 64,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  // master 0 (display reader)
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [DW-1:0]   m0_dat_ms,
  output logic [DW-1:0]   m0_dat_sm,
  output logic            m0_ack,
  // master 1 (frame writer)
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW/8-1:0] m1_sel,
  input  logic [DW-1:0]   m1_dat_ms,
  output logic [DW-1:0]   m1_dat_sm,
  output logic            m1_ack,
  // slave
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW/8-1:0] s_sel,
  output logic [DW-1:0]   s_dat_ms,
  input  logic [DW-1:0]   s_dat_sm,
  input  logic            s_ack,
  // status
  output logic [1:0]      gnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT0   = 2'd1,
    ST_GNT1   = 2'd2,
    ST_SWITCH = 2'd3
  } state_t;

  // Nine bits so that a saturated count of 255 plus one still compares correctly.
  localparam logic [8:0] C_QUOTA = 9'(QUOTA);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] ack_cnt_q, ack_cnt_d;
  logic       quota_hit;

  // Quota reached on the ack currently being delivered.
  always_comb begin
    quota_hit = (({1'b0, ack_cnt_q} + 9'd1) >= C_QUOTA);
  end

  // Next-state, last-grant and ack-counter logic.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    ack_cnt_d = ack_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc && m1_cyc) begin
          state_d = last_q ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc) begin
          state_d = ST_GNT0;
        end else if (m1_cyc) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc) begin
          state_d = ST_IDLE;
        end else if (s_ack && quota_hit && m1_cyc) begin
          state_d = ST_SWITCH;
        end else if (s_ack && (ack_cnt_q != 8'hFF)) begin
          ack_cnt_d = ack_cnt_q + 8'd1;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc) begin
          state_d = ST_IDLE;
        end else if (s_ack && quota_hit && m0_cyc) begin
          state_d = ST_SWITCH;
        end else if (s_ack && (ack_cnt_q != 8'hFF)) begin
          ack_cnt_d = ack_cnt_q + 8'd1;
        end
      end
      ST_SWITCH: begin
        // Prefer the master that did not hold the previous grant.
        if (!last_q) begin
          if (m1_cyc)      state_d = ST_GNT1;
          else if (m0_cyc) state_d = ST_GNT0;
          else             state_d = ST_IDLE;
        end else begin
          if (m0_cyc)      state_d = ST_GNT0;
          else if (m1_cyc) state_d = ST_GNT1;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh grant restarts the quota and records its owner.
    if ((state_q == ST_IDLE || state_q == ST_SWITCH) &&
        (state_d == ST_GNT0 || state_d == ST_GNT1)) begin
      ack_cnt_d = 8'd0;
      last_d    = (state_d == ST_GNT1);
    end
  end

  // State registers with synchronous reset; master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      ack_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

  // Bus multiplexing: pass the granted master through, everything low otherwise.
  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_sel     = '0;
    s_dat_ms  = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_dat_sm = '0;
    m1_dat_sm = '0;
    gnt       = 2'b00;
    case (state_q)
      ST_GNT0: begin
        s_cyc     = m0_cyc;
        s_stb     = m0_stb;
        s_we      = m0_we;
        s_adr     = m0_adr;
        s_sel     = m0_sel;
        s_dat_ms  = m0_dat_ms;
        m0_ack    = s_ack;
        m0_dat_sm = s_dat_sm;
        m1_dat_sm = s_dat_sm;
        gnt       = 2'b01;
      end
      ST_GNT1: begin
        s_cyc     = m1_cyc;
        s_stb     = m1_stb;
        s_we      = m1_we;
        s_adr     = m1_adr;
        s_sel     = m1_sel;
        s_dat_ms  = m1_dat_ms;
        m1_ack    = s_ack;
        m0_dat_sm = s_dat_sm;
        m1_dat_sm = s_dat_sm;
        gnt       = 2'b10;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wshb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wshb_arbiter
//  Description : Directed self-checking bench for wshb_arbiter. A QUOTA=4
//                instance carries most scenarios; a QUOTA=1 instance shares
//                the same stimulus for the single-ack alternation case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wshb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_ms;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_ms;
  logic [3:0]  m1_sel;
  logic [31:0] s_dat_sm;
  logic        s_ack;

  logic [31:0] m0_dat_sm, m1_dat_sm, s_adr, s_dat_ms;
  logic        m0_ack, m1_ack, s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [1:0]  gnt;

  logic [31:0] q1_m0_dat_sm, q1_m1_dat_sm, q1_s_adr, q1_s_dat_ms;
  logic        q1_m0_ack, q1_m1_ack, q1_s_cyc, q1_s_stb, q1_s_we;
  logic [3:0]  q1_s_sel;
  logic [1:0]  q1_gnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wshb_arbiter #(.QUOTA(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_sel(m0_sel), .m0_dat_ms(m0_dat_ms), .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_sel(m1_sel), .m1_dat_ms(m1_dat_ms), .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_ms(s_dat_ms), .s_dat_sm(s_dat_sm), .s_ack(s_ack), .gnt(gnt)
  );

  wshb_arbiter #(.QUOTA(1), .AW(32), .DW(32)) dut1 (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_sel(m0_sel), .m0_dat_ms(m0_dat_ms), .m0_dat_sm(q1_m0_dat_sm), .m0_ack(q1_m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_sel(m1_sel), .m1_dat_ms(m1_dat_ms), .m1_dat_sm(q1_m1_dat_sm), .m1_ack(q1_m1_ack),
    .s_cyc(q1_s_cyc), .s_stb(q1_s_stb), .s_we(q1_s_we), .s_adr(q1_s_adr), .s_sel(q1_s_sel),
    .s_dat_ms(q1_s_dat_ms), .s_dat_sm(s_dat_sm), .s_ack(s_ack), .gnt(q1_gnt)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_dat_ms = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_dat_ms = '0;
    s_dat_sm = '0; s_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    s_ack = 1'b1;   // stray ack while idle must not reach a master
    #1;
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || s_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b cyc=%b stb=%b we=%b required 00 0 0 0", gnt, s_cyc, s_stb, s_we);
    end
    checks++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack_ignored m0_ack=%b m1_ack=%b required 0 0", m0_ack, m1_ack);
    end
    s_ack = 1'b0;
  endtask

  task automatic test_m0_only_saturate();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_1000; m0_sel = 4'hF;
    #1;
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL grant_latency gnt=%b s_cyc=%b required 00 0", gnt, s_cyc);
    end
    tick();
    s_ack = 1; s_dat_sm = 32'hCAFE_0001;
    #1;
    checks++;
    if (gnt !== 2'b01 || s_cyc !== 1'b1 || s_adr !== 32'h0000_1000 || s_sel !== 4'hF) begin
      errors++;
      $display("FAIL gnt0_passthru gnt=%b cyc=%b adr=%h sel=%h required 01 1 00001000 f", gnt, s_cyc, s_adr, s_sel);
    end
    checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_dat_sm !== 32'hCAFE_0001 || m1_dat_sm !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL gnt0_ack_data m0_ack=%b m1_ack=%b d0=%h d1=%h required 1 0 cafe0001 cafe0001", m0_ack, m1_ack, m0_dat_sm, m1_dat_sm);
    end
    // 255 further acks: 256 in total, counter pinned at 255
    for (int i = 1; i < 256; i++) begin
      tick();
      checks++;
      if (gnt !== 2'b01 || m0_ack !== 1'b1) begin
        errors++;
        $display("FAIL m0_hold_%0d gnt=%b m0_ack=%b required 01 1", i, gnt, m0_ack);
      end
    end
    // m1 arrives; a saturated count already exceeds the quota
    tick();
    m1_cyc = 1; m1_stb = 1;
    #1;
    checks++;
    if (m0_ack !== 1'b1 || gnt !== 2'b01) begin
      errors++;
      $display("FAIL sat_last_ack m0_ack=%b gnt=%b required 1 01", m0_ack, gnt);
    end
    tick();
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL sat_switch gnt=%b s_cyc=%b m0_ack=%b m1_ack=%b required 00 0 0 0", gnt, s_cyc, m0_ack, m1_ack);
    end
    tick();
    checks++;
    if (gnt !== 2'b10 || m1_ack !== 1'b1) begin
      errors++;
      $display("FAIL sat_regrant gnt=%b m1_ack=%b required 10 1", gnt, m1_ack);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'hA000_0000; m0_sel = 4'hF;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'hB000_0040; m1_sel = 4'h3;
    m1_dat_ms = 32'h1234_5678; s_ack = 1;
    #1;
    checks++;
    if (gnt !== 2'b00 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL rr_request_cycle gnt=%b m0_ack=%b required 00 0", gnt, m0_ack);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (gnt !== 2'b01 || m0_ack !== 1'b1 || m1_ack !== 1'b0 || s_we !== 1'b0) begin
        errors++;
        $display("FAIL rr_m0_ack_%0d gnt=%b m0_ack=%b m1_ack=%b we=%b required 01 1 0 0", k, gnt, m0_ack, m1_ack, s_we);
      end
    end
    tick();
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL rr_switch1 gnt=%b cyc=%b stb=%b acks=%b%b required 00 0 0 00", gnt, s_cyc, s_stb, m0_ack, m1_ack);
    end
    // slave now acks every second cycle: four acks take eight cycles
    for (int k = 0; k < 8; k++) begin
      tick();
      s_ack = (k % 2 == 1);
      #1;
      checks++;
      if (gnt !== 2'b10 || s_we !== 1'b1 || s_adr !== 32'hB000_0040 || s_sel !== 4'h3 ||
          s_dat_ms !== 32'h1234_5678 || m1_ack !== s_ack || m0_ack !== 1'b0) begin
        errors++;
        $display("FAIL rr_m1_cycle_%0d gnt=%b we=%b adr=%h dat=%h m1_ack=%b m0_ack=%b required 10 1 b0000040 12345678 %b 0",
                 k, gnt, s_we, s_adr, s_dat_ms, m1_ack, m0_ack, s_ack);
      end
    end
    tick();
    s_ack = 0;
    #1;
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_adr !== 32'h0) begin
      errors++;
      $display("FAIL rr_switch2 gnt=%b cyc=%b adr=%h required 00 0 00000000", gnt, s_cyc, s_adr);
    end
    tick();
    checks++;
    if (gnt !== 2'b01 || s_adr !== 32'hA000_0000 || s_we !== 1'b0) begin
      errors++;
      $display("FAIL rr_back_to_m0 gnt=%b adr=%h we=%b required 01 a0000000 0", gnt, s_adr, s_we);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_drop_cyc();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0200;
    tick();
    s_ack = 1;
    #1;
    tick();
    checks++;
    if (gnt !== 2'b10 || m1_ack !== 1'b1) begin
      errors++;
      $display("FAIL drop_acks gnt=%b m1_ack=%b required 10 1", gnt, m1_ack);
    end
    tick();
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    #1;
    checks++;
    if (s_cyc !== 1'b0 || gnt !== 2'b10) begin
      errors++;
      $display("FAIL drop_same_cycle s_cyc=%b gnt=%b required 0 10", s_cyc, gnt);
    end
    tick();
    checks++;
    if (gnt !== 2'b00) begin
      errors++;
      $display("FAIL drop_to_idle gnt=%b required 00", gnt);
    end
    m0_cyc = 1; m0_stb = 1;
    tick();
    checks++;
    if (gnt !== 2'b01 || s_cyc !== 1'b1) begin
      errors++;
      $display("FAIL drop_then_m0 gnt=%b s_cyc=%b required 01 1", gnt, s_cyc);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_0300; m1_sel = 4'hF;
    tick();
    checks++;
    if (gnt !== 2'b10 || s_stb !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_pre gnt=%b s_stb=%b required 10 1", gnt, s_stb);
    end
    rst = 1;
    tick();
    s_ack = 1;   // late ack from the abandoned transfer
    #1;
    checks++;
    if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || s_we !== 1'b0 || s_adr !== 32'h0 || s_sel !== 4'h0) begin
      errors++;
      $display("FAIL mid_rst_bus gnt=%b cyc=%b stb=%b we=%b adr=%h sel=%h required 00 0 0 0 0 0", gnt, s_cyc, s_stb, s_we, s_adr, s_sel);
    end
    checks++;
    if (m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_late_ack m1_ack=%b required 0", m1_ack);
    end
    rst = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_quota_one();
    logic [1:0] exp_g [5];
    exp_g[0] = 2'b01; exp_g[1] = 2'b00; exp_g[2] = 2'b10; exp_g[3] = 2'b00; exp_g[4] = 2'b01;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (q1_gnt !== exp_g[k] || q1_m0_ack !== exp_g[k][0] || q1_m1_ack !== exp_g[k][1]) begin
        errors++;
        $display("FAIL quota1_step_%0d gnt=%b m0_ack=%b m1_ack=%b required %b %b %b",
                 k, q1_gnt, q1_m0_ack, q1_m1_ack, exp_g[k], exp_g[k][0], exp_g[k][1]);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_m0_only_saturate();
    test_round_robin();
    test_drop_cyc();
    test_reset_mid_transfer();
    test_quota_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
